// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, TX FSM state encoding and the baud divider macro (also used by the receiver).
`ifndef UART_DIV
`define UART_DIV(clk_hz, baud) ((clk_hz) / (baud))
`endif
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
endpackage

// File: rtl/uart_tx_sync_fifo.sv
// uart_tx_sync_fifo: synchronous FIFO with registered full/empty/count and a one-cycle drop pulse.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_sync_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic             o_dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full, r_empty, r_dropped;
  logic             w_push_ok, w_pop_ok;
  logic [CNT_W-1:0] w_count_nx;
  assign w_pop_ok   = i_pop && !r_empty;
  assign w_push_ok  = i_push && (!r_full || w_pop_ok);
  assign w_count_nx = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_dropped <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_count_nx;
      r_full    <= w_count_nx == CNT_W'(FIFO_DEPTH);
      r_empty   <= w_count_nx == '0;
      r_dropped <= i_push && !w_push_ok;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end
  assign o_data    = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;
  assign o_dropped = r_dropped;
endmodule

// File: rtl/uart_tx_fifo_mmio.sv
// uart_tx_fifo_mmio: MMIO-fed UART transmitter, FIFO-buffered, 8N1 LSB first (8E1 when UART_TX_PARITY_EN is defined).
// Frames run back-to-back while the FIFO holds data; the line idles high.
module uart_tx_fifo_mmio
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 128_000,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             iFpgaClk,
  input  logic             iFpgaRstN,
  input  logic             iWrEn,
  input  logic [7:0]       iWrData,
  output logic             oFull,
  output logic             oEmpty,
  output logic             oBusy,
  output logic [CNT_W-1:0] oCount,
  output logic             oDropped,
  output logic             oFpgaUartToPc
);
  localparam int DIV = `UART_DIV(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  uart_state_e r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shreg;
  logic [2:0]    r_idx;
  logic [7:0]    w_head;
  logic          w_pop, w_line, w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif
  uart_tx_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_fifo (
    .i_clk     (iFpgaClk),
    .i_rst_n   (iFpgaRstN),
    .i_push    (iWrEn),
    .i_data    (iWrData),
    .i_pop     (w_pop),
    .o_data    (w_head),
    .o_full    (oFull),
    .o_empty   (oEmpty),
    .o_count   (oCount),
    .o_dropped (oDropped)
  );
  assign w_bit_end = (r_state != IDLE) && (r_cnt == CW'(DIV - 1));
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_line     = UART_IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        w_pop      = !oEmpty;
        w_state_nx = oEmpty ? IDLE : START;
      end
      START: begin
        w_line = UART_START_LEVEL;
        if (w_bit_end) w_state_nx = DATA;
      end
      DATA: begin
        w_line = r_shreg[0];
`ifdef UART_TX_PARITY_EN
        if (w_bit_end && r_idx == 3'(UART_DATA_BITS - 1)) w_state_nx = PARITY;
`else
        if (w_bit_end && r_idx == 3'(UART_DATA_BITS - 1)) w_state_nx = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_line = r_par;
        if (w_bit_end) w_state_nx = STOP;
      end
`endif
      STOP: begin
        // last stop clock chains straight into the next frame when data is waiting
        if (w_bit_end) begin
          w_pop      = !oEmpty;
          w_state_nx = oEmpty ? IDLE : START;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
    if (!iFpgaRstN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= (r_state == IDLE || w_bit_end) ? '0 : r_cnt + CW'(1);
      r_shreg <= w_pop ? w_head : (r_state == DATA && w_bit_end) ? r_shreg >> 1 : r_shreg;
      r_idx   <= (r_state != DATA) ? '0 : w_bit_end ? r_idx + 3'd1 : r_idx;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
    if (!iFpgaRstN) r_par <= 1'b0;
    else if (w_pop) r_par <= ^w_head;
  end
`endif
  assign oBusy         = r_state != IDLE;
  assign oFpgaUartToPc = w_line;
endmodule

// File: tb/tb_uart_tx_fifo_mmio.sv
// tb_uart_tx_fifo_mmio: frame-level reference model checked every cycle, plus directed literal checks and random pushes.
module tb_uart_tx_fifo_mmio;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full, empty, busy, dropped, line;
  logic [2:0] count;
  int checks = 0, failures = 0;

  uart_tx_fifo_mmio #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .iFpgaClk      (clk),
    .iFpgaRstN     (rst_n),
    .iWrEn         (wr),
    .iWrData       (data),
    .oFull         (full),
    .oEmpty        (empty),
    .oBusy         (busy),
    .oCount        (count),
    .oDropped      (dropped),
    .oFpgaUartToPc (line)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: a byte queue plus the currently transmitted frame and its clock offset
  logic [7:0] mq[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_busy = 1'b0, m_drop = 1'b0, m_end, m_pop, m_acc;
  int         m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_drop = 1'b0;
    end else begin
      m_end  = m_busy && m_t == FL - 1;
      m_pop  = (!m_busy || m_end) && mq.size() > 0;
      m_acc  = wr && (mq.size() < DEPTH || m_pop);
      m_drop = wr && !m_acc;
      if (m_pop) m_cur = mq.pop_front();
      if (m_acc) mq.push_back(data);
      if (m_pop) begin
        m_busy = 1'b1;
        m_t    = 0;
      end else if (m_end) m_busy = 1'b0;
      else if (m_busy) m_t++;
    end
  end

  function automatic logic m_line();
    int k;
    k = m_t / DIV;
    if (!m_busy) return 1'b1;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    chk("line", int'(line), int'(m_line()));
    chk("busy", int'(busy), int'(m_busy));
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("dropped", int'(dropped), int'(m_drop));
  end

  int run_len = 0, last_run = 0, peak = 0;
  bit drop_seen = 1'b0;
  always @(negedge clk) begin
    if (busy) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (int'(count) > peak) peak = int'(count);
    if (dropped) drop_seen = 1'b1;
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || !empty) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic push1(input logic [7:0] b);
    @(negedge clk);
    wr   = 1'b1;
    data = b;
  endtask

  initial begin
    logic [10:0] got;
    int n;
    got = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_line", int'(line), 1);
    chk("idle_count", int'(count), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_empty", int'(empty), 1);
    // single byte: latency and mid-bit samples
`ifdef UART_TX_PARITY_EN
    push1(8'h07);
`else
    push1(8'hA5);
`endif
    @(negedge clk);
    wr = 1'b0;
    chk("count_after_write", int'(count), 1);
    chk("line_1clk", int'(line), 1);
    @(negedge clk);
    chk("line_2clk", int'(line), 0);
    repeat (5) @(negedge clk);
    for (int k = 0; k < FL / DIV; k++) begin
      got[k] = line;
      repeat (10) @(negedge clk);
    end
    wait_idle(200);
`ifdef UART_TX_PARITY_EN
    chk("bits_07", int'(got), int'(11'b11000001110));
    chk("parity_bit", int'(got[9]), 1);
`else
    chk("bits_a5", int'(got[9:0]), int'(10'b1101001010));
`endif
    chk("frame_len", last_run, FL);
    // four consecutive writes: back-to-back frames
    peak      = 0;
    drop_seen = 1'b0;
    push1(8'h55);
    push1(8'h0F);
    push1(8'hFF);
    push1(8'h00);
    @(negedge clk);
    wr = 1'b0;
    wait_idle(6 * FL);
    chk("peak_count", peak, 3);
    chk("b2b_len", last_run, 4 * FL);
    chk("b2b_no_drop", int'(drop_seen), 0);
    // overflow: sixth write hits a full FIFO with no pop
    for (int i = 0; i < 6; i++) push1(8'h10 + 8'(i));
    @(negedge clk);
    wr = 1'b0;
    chk("drop_pulse", int'(dropped), 1);
    chk("drop_count", int'(count), 4);
    chk("drop_full", int'(full), 1);
    @(negedge clk);
    chk("drop_one_clk", int'(dropped), 0);
    // write into a full FIFO on the cycle the transmitter pops
    n = 0;
    while (!(m_busy && m_t == FL - 1 && mq.size() == DEPTH) && n < 3 * FL) begin
      @(negedge clk);
      n++;
    end
    chk("pop_slot_found", int'(n < 3 * FL), 1);
    wr   = 1'b1;
    data = 8'hC3;
    @(negedge clk);
    wr = 1'b0;
    chk("pop_push_count", int'(count), 4);
    chk("pop_push_nodrop", int'(dropped), 0);
    wait_idle(8 * FL);
    // reset in the middle of data bit 3
    push1(8'hF0);
    @(negedge clk);
    wr = 1'b0;
    n  = 0;
    while (!(m_busy && m_t == 45) && n < 2 * FL) begin
      @(negedge clk);
      n++;
    end
    chk("bit3_line_low", int'(line), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_line", int'(line), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push1(8'h3C);
    @(negedge clk);
    wr = 1'b0;
    wait_idle(3 * FL);
    chk("post_rst_frame_len", last_run, FL);
    // random pushes, checked cycle by cycle against the model
    repeat (3000) begin
      @(negedge clk);
      wr   = $urandom_range(0, 19) == 0;
      data = 8'($urandom);
    end
    @(negedge clk);
    wr = 1'b0;
    wait_idle(8 * FL);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
